gb_timer_irq_ctrl: RTL and testbench
====================================

Name: gb_timer_irq_ctrl

Overview:
- Memory-mapped timer (DIV/TIMA/TMA/TAC) plus interrupt flag/enable registers (IF/IE) on the CPU's side of the system bus.
- Sits directly upstream of gb_cpu: drives its reg_IF/reg_IE inputs and consumes its clear_interrupt_flag pulse.
- Decodes CPU bus accesses (addr/data/write strobe) for FF04-FF07, FF0F and FFFF.
- Merges peripheral interrupt requests with the internal timer overflow request.

Parameters:
- DIV_STEP, 4, amount added to the 16-bit system counter per clk (clk = one M-cycle = 4 T-cycles).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- addr_i  in  16  CPU address bus (gb_cpu addr_o)
- data_i  in  8  CPU write data (gb_cpu data_o)
- wr_en_i  in  1  CPU write strobe (gb_cpu drive_data_bus)
- data_o  out  8  read data for addressed register; 8'hFF when not addressed
- sel_o  out  1  high when addr_i hits a register owned by this block (combinational)
- irq_i  in  5  peripheral request pulses: bit0 VBlank, 1 STAT, 2 timer (external, ORed), 3 serial, 4 joypad
- clear_interrupt_flag  in  1  CPU dispatch acknowledge
- reg_IF  out  8  {3'b000, if_q[4:0]}
- reg_IE  out  8  ie_q[7:0]

Behaviour:
- Reset (reset==0 at clk edge):
  - sys_cnt=0, TIMA=0, TMA=0, TAC=0, if_q=0, ie_q=0, ovf_pend=0, prev_tick=0.
  - Outputs: reg_IF=8'h00, reg_IE=8'h00.
  - Reset overrides all same-cycle writes and requests, including mid-overflow.
- Register map (reads combinational):
  - FF04 DIV = sys_cnt[15:8]; any write clears sys_cnt to 0 (data ignored).
  - FF05 TIMA; FF06 TMA.
  - FF07 TAC: reads {5'b11111, TAC[2:0]}.
  - FF0F IF: reads {3'b111, if_q}; write loads if_q = data_i[4:0].
  - FFFF IE: full 8-bit read/write.
  - Writes take effect at the clk edge where wr_en_i=1.
- System counter: sys_cnt += DIV_STEP each clk, wraps 16'hFFFF->0.
- Timer tick:
  - tick = TAC[2] & sys_cnt[bit].
  - bit selected by TAC[1:0]: 00->9, 01->3, 10->5, 11->7, giving periods of 256/4/16/64 clks.
  - prev_tick is registered each clk. A falling edge (prev_tick=1, tick=0) increments TIMA.
  - Falling edges caused by a DIV write or a TAC change also increment TIMA (same rule, no special casing).
- Overflow state machine: IDLE -> RELOAD -> IDLE.
  - IDLE: increment of TIMA==8'hFF sets TIMA=8'h00 and ovf_pend=1 (enter RELOAD).
  - RELOAD (exactly one clk later): TIMA<=TMA, if_q[2]<=1, ovf_pend<=0.
  - A CPU write to TIMA during the overflow cycle (TIMA reading 00) cancels the reload and the IRQ; the written value wins.
  - A TMA write during the RELOAD cycle: TIMA takes the new TMA value.
- IF update priority per bit, lowest to highest:
  1. hold
  2. CPU write
  3. clear_interrupt_flag
  4. set from irq_i or timer RELOAD
  - A set wins over clear and write in the same cycle.
- clear_interrupt_flag clears the lowest-index bit of (if_q & ie_q[4:0]). If that mask is zero, no change.
- No read side effects. Unmapped addresses: data_o=8'hFF, sel_o=0.

Optional Feature:
- Macro: GB_TIMER_EN.
- Defined: timer as above.
- Undefined:
  - No sys_cnt/TIMA/TMA/TAC logic.
  - FF04-FF07 read 8'hFF with sel_o=0; writes to them are ignored.
  - if_q[2] is set only by irq_i[2].
  - IF/IE behaviour is unchanged.

Test Plan:
- Reset then 64 clks -> DIV=8'h01 (sys_cnt=256); write FF04 -> next read DIV=8'h00; reg_IF=8'h00, reg_IE=8'h00 throughout.
- TAC=8'h05, TMA=8'hF0, TIMA=8'hFE -> TIMA=FF after 4 clks, 00 after 8, one clk later TIMA=F0 and reg_IF=8'h04.
- Repeat the overflow, writing TIMA=8'h33 in the cycle TIMA reads 00 -> TIMA stays 33, reg_IF[2] stays 0.
- IE=8'h1F, irq_i=5'b10010 pulse -> reg_IF=8'h12; clear_interrupt_flag -> 8'h10; again -> 8'h00; again -> no change.
- Same cycle: irq_i[0]=1, clear_interrupt_flag=1, if_q=8'h01, IE=8'h01 -> reg_IF stays 8'h01. Separately, write FF0F=8'hFF -> reads back 8'hFF, reg_IF=8'h1F.
- reset driven low mid-RELOAD (TIMA=00, ovf_pend=1) -> next clk all registers 0, IF[2] never set; build without GB_TIMER_EN -> FF05 reads 8'hFF.

Source files
------------

// File: rtl/gb_timer_irq_ctrl.sv
// gb_timer_irq_ctrl: DIV/TIMA/TMA/TAC timer and IF/IE interrupt registers on the CPU bus.
// The timer is built only when GB_TIMER_EN is defined; otherwise FF04-FF07 are unmapped.
module gb_timer_irq_ctrl
`ifdef GB_TIMER_EN
#(
    parameter int DIV_STEP = 4
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr_i,
    input  logic [7:0]  data_i,
    input  logic        wr_en_i,
    output logic [7:0]  data_o,
    output logic        sel_o,
    input  logic [4:0]  irq_i,
    input  logic        clear_interrupt_flag,
    output logic [7:0]  reg_IF,
    output logic [7:0]  reg_IE
);
    logic       hit_if, hit_ie, wr_if, wr_ie, tmr_sel;
    logic [4:0] if_q, if_d, pend, clr_mask, tmr_set;
    logic [7:0] ie_q, ie_d, tmr_rd;

    assign hit_if = addr_i == 16'hFF0F;
    assign hit_ie = addr_i == 16'hFFFF;
    assign wr_if  = wr_en_i & hit_if;
    assign wr_ie  = wr_en_i & hit_ie;

`ifdef GB_TIMER_EN
    typedef enum logic {IDLE, RELOAD} ovf_t;
    localparam logic [15:0] STEP = 16'(DIV_STEP);

    ovf_t        st_q, st_d;
    logic [15:0] sys_q, sys_d;
    logic [7:0]  tima_q, tima_d, tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        prev_q, tick, wr_div, wr_tima, wr_tma, wr_tac;

    assign tmr_sel = addr_i[15:2] == 14'h3FC1;
    assign wr_div  = wr_en_i & tmr_sel & (addr_i[1:0] == 2'd0);
    assign wr_tima = wr_en_i & tmr_sel & (addr_i[1:0] == 2'd1);
    assign wr_tma  = wr_en_i & tmr_sel & (addr_i[1:0] == 2'd2);
    assign wr_tac  = wr_en_i & tmr_sel & (addr_i[1:0] == 2'd3);
    assign tick = tac_q[2] & (tac_q[1:0] == 2'd0 ? sys_q[9] :
                              tac_q[1:0] == 2'd1 ? sys_q[3] :
                              tac_q[1:0] == 2'd2 ? sys_q[5] : sys_q[7]);
    // a TIMA write during the reload cycle cancels both the reload and the request
    assign tmr_set = {2'b00, st_q == RELOAD && !wr_tima, 2'b00};
    assign tmr_rd = addr_i[1:0] == 2'd0 ? sys_q[15:8] :
                    addr_i[1:0] == 2'd1 ? tima_q :
                    addr_i[1:0] == 2'd2 ? tma_q : {5'b11111, tac_q};

    always_comb begin
        sys_d  = wr_div ? 16'h0000 : sys_q + STEP;
        tma_d  = wr_tma ? data_i : tma_q;
        tac_d  = wr_tac ? data_i[2:0] : tac_q;
        st_d   = IDLE;
        tima_d = tima_q;
        if (wr_tima)
            tima_d = data_i;
        else if (st_q == RELOAD)
            tima_d = tma_d;
        else if (prev_q && !tick) begin
            tima_d = tima_q + 8'd1;
            st_d   = tima_q == 8'hFF ? RELOAD : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q   <= IDLE;
            sys_q  <= 16'h0000;
            tima_q <= 8'h00;
            tma_q  <= 8'h00;
            tac_q  <= 3'b000;
            prev_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            sys_q  <= sys_d;
            tima_q <= tima_d;
            tma_q  <= tma_d;
            tac_q  <= tac_d;
            prev_q <= tick;
        end
    end
`else
    assign tmr_sel = 1'b0;
    assign tmr_rd  = 8'hFF;
    assign tmr_set = 5'b00000;
`endif

    // isolate the lowest pending-and-enabled bit for the dispatch acknowledge
    assign pend     = if_q & ie_q[4:0];
    assign clr_mask = clear_interrupt_flag ? pend & (~pend + 5'd1) : 5'd0;
    assign if_d     = ((wr_if ? data_i[4:0] : if_q) & ~clr_mask) | irq_i | tmr_set;
    assign ie_d     = wr_ie ? data_i : ie_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            if_q <= 5'd0;
            ie_q <= 8'h00;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
        end
    end

    assign sel_o  = tmr_sel | hit_if | hit_ie;
    assign data_o = tmr_sel ? tmr_rd : hit_if ? {3'b111, if_q} : hit_ie ? ie_q : 8'hFF;
    assign reg_IF = {3'b000, if_q};
    assign reg_IE = ie_q;
endmodule

// File: tb/tb_gb_timer_irq_ctrl.sv
// tb_gb_timer_irq_ctrl: table-driven IF/IE checks plus timer overflow sequences (GB_TIMER_EN builds).
module tb_gb_timer_irq_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_i;
    logic [7:0]  data_i;
    logic        wr_en_i;
    logic [7:0]  data_o;
    logic        sel_o;
    logic [4:0]  irq_i;
    logic        clear_interrupt_flag;
    logic [7:0]  reg_IF;
    logic [7:0]  reg_IE;

    always #5 clk = ~clk;

    gb_timer_irq_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .addr_i              (addr_i),
        .data_i              (data_i),
        .wr_en_i             (wr_en_i),
        .data_o              (data_o),
        .sel_o               (sel_o),
        .irq_i               (irq_i),
        .clear_interrupt_flag(clear_interrupt_flag),
        .reg_IF              (reg_IF),
        .reg_IE              (reg_IE)
    );

    localparam int K_IF = 0, K_IE = 1, K_DO = 2, K_SEL = 3;
    typedef logic [8*12-1:0] tag_t;
    typedef struct {
        tag_t       name;
        int         idx;
        int         kind;
        logic [7:0] v;
    } exp_t;
    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wr;
        logic [4:0]  irq;
        logic        clr;
        logic [4:0]  eif;
        logic [7:0]  eie;
        logic [7:0]  edo;
        logic        esel;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[18];
    int   checks = 0;
    int   errors = 0;
    int   vidx = -1;

    function automatic logic [7:0] act(input int k);
        return k == K_IF ? reg_IF : k == K_IE ? reg_IE : k == K_DO ? data_o : {7'b0, sel_o};
    endfunction

    task automatic push(input tag_t n, input int k, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.idx  = vidx;
        e.kind = k;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = act(e.kind);
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL %0s[%0d]: got %02h expected %02h", e.name, e.idx, a, e.v);
            end
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic [4:0] irq, input logic clr);
        @(negedge clk);
        addr_i = a;
        data_i = d;
        wr_en_i = w;
        irq_i = irq;
        clear_interrupt_flag = clr;
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic rd(input logic [15:0] a);
        @(negedge clk);
        addr_i = a;
        wr_en_i = 1'b0;
        irq_i = 5'd0;
        clear_interrupt_flag = 1'b0;
        #1;
        drain();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(16'h0000, 8'h00, 1'b0, 5'd0, 1'b0);
        cyc(16'h0000, 8'h00, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
    endtask

`ifdef GB_TIMER_EN
    // Drives TIMA from FE through FF to the overflow cycle where it reads 00.
    task automatic ovf_to_zero();
        do_reset();
        push("ovf_div", K_DO, 8'h00); cyc(16'hFF04, 8'h00, 1'b1, 5'd0, 1'b0);
        push("ovf_tma", K_DO, 8'hF0); cyc(16'hFF06, 8'hF0, 1'b1, 5'd0, 1'b0);
        push("ovf_tac", K_DO, 8'hFD); cyc(16'hFF07, 8'h05, 1'b1, 5'd0, 1'b0);
        push("ovf_tima", K_DO, 8'hFE); cyc(16'hFF05, 8'hFE, 1'b1, 5'd0, 1'b0);
        push("ovf_fe", K_DO, 8'hFE); cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push("ovf_ff", K_DO, 8'hFF);
            cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
        end
        push("ovf_00", K_DO, 8'h00);
        push("ovf_if0", K_IF, 8'h00);
        cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b0;
        addr_i = 16'h0000;
        data_i = 8'h00;
        wr_en_i = 1'b0;
        irq_i = 5'd0;
        clear_interrupt_flag = 1'b0;
        tbl[0]  = '{16'hFFFF, 8'h1F, 1'b1, 5'h00, 1'b0, 5'h00, 8'h1F, 8'h1F, 1'b1};
        tbl[1]  = '{16'hFFFF, 8'h00, 1'b0, 5'h12, 1'b0, 5'h12, 8'h1F, 8'h1F, 1'b1};
        tbl[2]  = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h10, 8'h1F, 8'hF0, 1'b1};
        tbl[3]  = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h00, 8'h1F, 8'hE0, 1'b1};
        tbl[4]  = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h00, 8'h1F, 8'hE0, 1'b1};
        tbl[5]  = '{16'hFFFF, 8'h01, 1'b1, 5'h01, 1'b0, 5'h01, 8'h01, 8'h01, 1'b1};
        tbl[6]  = '{16'hFF0F, 8'h00, 1'b0, 5'h01, 1'b1, 5'h01, 8'h01, 8'hE1, 1'b1};
        tbl[7]  = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h00, 8'h01, 8'hE0, 1'b1};
        tbl[8]  = '{16'hFF0F, 8'hFF, 1'b1, 5'h00, 1'b0, 5'h1F, 8'h01, 8'hFF, 1'b1};
        tbl[9]  = '{16'hFF0F, 8'h00, 1'b1, 5'h04, 1'b0, 5'h04, 8'h01, 8'hE4, 1'b1};
        tbl[10] = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h04, 8'h01, 8'hE4, 1'b1};
        tbl[11] = '{16'hFFFF, 8'hFF, 1'b1, 5'h00, 1'b0, 5'h04, 8'hFF, 8'hFF, 1'b1};
        tbl[12] = '{16'hFF0F, 8'h00, 1'b0, 5'h00, 1'b1, 5'h00, 8'hFF, 8'hE0, 1'b1};
        tbl[13] = '{16'hFF0F, 8'h03, 1'b1, 5'h00, 1'b1, 5'h03, 8'hFF, 8'hE3, 1'b1};
        tbl[14] = '{16'hFF0F, 8'h07, 1'b1, 5'h00, 1'b1, 5'h06, 8'hFF, 8'hE6, 1'b1};
        tbl[15] = '{16'hFF10, 8'h00, 1'b0, 5'h00, 1'b0, 5'h06, 8'hFF, 8'hFF, 1'b0};
        tbl[16] = '{16'h0000, 8'h00, 1'b1, 5'h00, 1'b0, 5'h06, 8'hFF, 8'hFF, 1'b0};
        tbl[17] = '{16'hFF0F, 8'h00, 1'b0, 5'h10, 1'b1, 5'h14, 8'hFF, 8'hF4, 1'b1};

        // reset must override same-cycle writes and requests
        push("rst_if", K_IF, 8'h00); push("rst_ie", K_IE, 8'h00);
        cyc(16'hFFFF, 8'hFF, 1'b1, 5'h1F, 1'b0);
        push("rst_if", K_IF, 8'h00); push("rst_ie", K_IE, 8'h00);
        cyc(16'hFF0F, 8'hFF, 1'b1, 5'h1F, 1'b1);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            vidx = i;
            push("tbl_if", K_IF, {3'b000, tbl[i].eif});
            push("tbl_ie", K_IE, tbl[i].eie);
            push("tbl_do", K_DO, tbl[i].edo);
            push("tbl_sel", K_SEL, {7'b0, tbl[i].esel});
            cyc(tbl[i].addr, tbl[i].data, tbl[i].wr, tbl[i].irq, tbl[i].clr);
        end
        vidx = -1;

        do_reset();
        push("irq2_if", K_IF, 8'h04); push("irq2_ie", K_IE, 8'h00);
        cyc(16'h0000, 8'h00, 1'b0, 5'h04, 1'b0);

`ifdef GB_TIMER_EN
        do_reset();
        for (int i = 1; i <= 64; i++) begin
            if (i == 63) push("div_00", K_DO, 8'h00);
            if (i == 64) push("div_01", K_DO, 8'h01);
            cyc(16'hFF04, 8'h00, 1'b0, 5'd0, 1'b0);
        end
        push("div_clr", K_DO, 8'h00); push("div_if", K_IF, 8'h00); push("div_ie", K_IE, 8'h00);
        cyc(16'hFF04, 8'h5A, 1'b1, 5'd0, 1'b0);
        push("tac_rd", K_DO, 8'hF8); push("tac_sel", K_SEL, 8'h01);
        rd(16'hFF07);

        ovf_to_zero();
        push("rld_tima", K_DO, 8'hF0); push("rld_if", K_IF, 8'h04);
        cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);

        ovf_to_zero();
        push("cnc_tima", K_DO, 8'h33); push("cnc_if", K_IF, 8'h00);
        cyc(16'hFF05, 8'h33, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            push("cnc_hold", K_DO, 8'h33); push("cnc_if", K_IF, 8'h00);
            cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
        end

        ovf_to_zero();
        push("tmaw_tma", K_DO, 8'h77); push("tmaw_if", K_IF, 8'h04);
        cyc(16'hFF06, 8'h77, 1'b1, 5'd0, 1'b0);
        push("tmaw_tima", K_DO, 8'h77);
        rd(16'hFF05);

        ovf_to_zero();
        reset = 1'b0;
        push("rstm_tima", K_DO, 8'h00); push("rstm_if", K_IF, 8'h00);
        cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
        push("rstm_tma", K_DO, 8'h00); rd(16'hFF06);
        push("rstm_tac", K_DO, 8'hF8); rd(16'hFF07);
        push("rstm_div", K_DO, 8'h00); rd(16'hFF04);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("rstm_if2", K_IF, 8'h00); push("rstm_tima2", K_DO, 8'h00);
            cyc(16'hFF05, 8'h00, 1'b0, 5'd0, 1'b0);
        end
`else
        for (int i = 0; i < 4; i++) begin
            push("nt_do", K_DO, 8'hFF); push("nt_sel", K_SEL, 8'h00);
            rd(16'hFF04 + 16'(i));
        end
        push("nt_wr", K_DO, 8'hFF); push("nt_wsel", K_SEL, 8'h00);
        cyc(16'hFF05, 8'h33, 1'b1, 5'd0, 1'b0);
        push("nt_rd", K_DO, 8'hFF); push("nt_if", K_IF, 8'h04);
        rd(16'hFF05);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
